// File: rtl/digiclk_cpu_oci_dct_packer.sv
// DCT trace packer: appends 2-bit trace codes into a 30-bit fill buffer and
// hands full or flushed frames to a one-deep valid/ready holding register.
module digiclk_cpu_oci_dct_packer #(
    parameter int unsigned ENTRY_W = 2,
    parameter int unsigned ENTRIES = 15
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       dct_valid_i,
    input  logic [ENTRY_W-1:0]         dct_code_i,
    input  logic                       flush_i,
    input  logic                       frame_ready_i,
    input  logic                       overflow_clr_i,
    output logic [ENTRY_W*ENTRIES-1:0] dct_buffer_o,
    output logic [3:0]                 dct_count_o,
    output logic                       frame_valid_o,
    output logic [ENTRY_W*ENTRIES-1:0] frame_data_o,
    output logic [3:0]                 frame_count_o,
    output logic                       overflow_o
);

    localparam int unsigned BufW = ENTRY_W * ENTRIES;
    localparam logic [3:0]  CntFull = 4'(ENTRIES);

    typedef enum logic {StEmpty, StFull} hold_e;

    hold_e             hold_q, hold_d;
    logic [BufW-1:0]   buf_q, buf_d;
    logic [3:0]        count_q, count_d;
    logic [BufW-1:0]   frame_data_q, frame_data_d;
    logic [3:0]        frame_count_q, frame_count_d;
    logic              pending_q, pending_d;
    logic              overflow_q, overflow_d;

    logic              accept;
    logic              drop;
    logic [BufW-1:0]   buf_next;
    logic [3:0]        count_next;
    logic              slot_avail;
    logic              push_need;
    logic              push;

    // Append datapath: fold this cycle's accepted code into the buffer.
    always_comb begin
        accept     = dct_valid_i && (count_q < CntFull);
        drop       = dct_valid_i && !accept;
        buf_next   = buf_q;
        count_next = count_q;
        if (accept) begin
            // Upper bits above count_q are always zero, so OR-ing is a write.
            buf_next   = buf_q | ({{(BufW-ENTRY_W){1'b0}}, dct_code_i} << (ENTRY_W * count_q));
            count_next = count_q + 4'd1;
        end
    end

    // Holding-register FSM plus push/flush/overflow next-state.
    always_comb begin
        hold_d        = hold_q;
        buf_d         = buf_next;
        count_d       = count_next;
        frame_data_d  = frame_data_q;
        frame_count_d = frame_count_q;
        pending_d     = pending_q;
        overflow_d    = overflow_q;

        slot_avail = (hold_q == StEmpty) || frame_ready_i;
        push_need  = (count_next == CntFull) ||
                     ((flush_i || pending_q) && (count_next != 4'd0));
        push       = push_need && slot_avail;

        if (push) begin
            hold_d        = StFull;
            frame_data_d  = buf_next;
            frame_count_d = count_next;
            buf_d         = '0;
            count_d       = 4'd0;
            pending_d     = 1'b0;
        end else begin
            // A blocked push remembers itself; a flush on an empty buffer is dropped.
            pending_d = push_need;
            if (hold_q == StFull && frame_ready_i) begin
                hold_d = StEmpty;
            end
        end

        // Set beats clear when both happen together.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hold_q        <= StEmpty;
            buf_q         <= '0;
            count_q       <= 4'd0;
            frame_data_q  <= '0;
            frame_count_q <= 4'd0;
            pending_q     <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            hold_q        <= hold_d;
            buf_q         <= buf_d;
            count_q       <= count_d;
            frame_data_q  <= frame_data_d;
            frame_count_q <= frame_count_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
        end
    end

    assign dct_buffer_o  = buf_q;
    assign dct_count_o   = count_q;
    assign frame_valid_o = (hold_q == StFull);
    assign frame_data_o  = frame_data_q;
    assign frame_count_o = frame_count_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_digiclk_cpu_oci_dct_packer.sv
// Self-checking bench for the DCT packer: directed scenarios plus a random run
// checked against a queue-based reference model.
module tb_digiclk_cpu_oci_dct_packer;

    logic        clk;
    logic        reset;
    logic        dct_valid;
    logic [1:0]  dct_code;
    logic        flush;
    logic        frame_ready;
    logic        overflow_clr;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frame_valid;
    logic [29:0] frame_data;
    logic [3:0]  frame_count;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: codes waiting in the fill buffer, and the held frame.
    int          m_codes[$];
    bit          m_hold_valid;
    logic [29:0] m_hold_data;
    int          m_hold_count;
    bit          m_pending;
    bit          m_ovf;

    digiclk_cpu_oci_dct_packer dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .dct_valid_i    (dct_valid),
        .dct_code_i     (dct_code),
        .flush_i        (flush),
        .frame_ready_i  (frame_ready),
        .overflow_clr_i (overflow_clr),
        .dct_buffer_o   (dct_buffer),
        .dct_count_o    (dct_count),
        .frame_valid_o  (frame_valid),
        .frame_data_o   (frame_data),
        .frame_count_o  (frame_count),
        .overflow_o     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] pack(input int codes[$]);
        logic [29:0] d = '0;
        for (int i = 0; i < codes.size(); i++) d[2*i +: 2] = 2'(codes[i]);
        return d;
    endfunction

    function automatic void model_reset();
        m_codes.delete();
        m_hold_valid = 0;
        m_hold_data  = '0;
        m_hold_count = 0;
        m_pending    = 0;
        m_ovf        = 0;
    endfunction

    // One clock of behaviour, from the rules: accept/drop, then push or hold.
    function automatic void model_step(bit v, int c, bit f, bit r, bit clr);
        bit slot = !m_hold_valid || r;
        bit dropped = 0;
        bit need;
        if (v) begin
            if (m_codes.size() < 15) m_codes.push_back(c);
            else dropped = 1;
        end
        need = (m_codes.size() == 15) || ((f || m_pending) && m_codes.size() > 0);
        if (need && slot) begin
            m_hold_valid = 1;
            m_hold_data  = pack(m_codes);
            m_hold_count = m_codes.size();
            m_codes.delete();
            m_pending    = 0;
        end else begin
            if (m_hold_valid && r) m_hold_valid = 0;
            m_pending = need;
        end
        if (dropped) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, sample at +1.
    task automatic tick(bit v, logic [1:0] c, bit f, bit r, bit clr);
        dct_valid    = v;
        dct_code     = c;
        flush        = f;
        frame_ready  = r;
        overflow_clr = clr;
        @(posedge clk);
        model_step(v, int'(c), f, r, clr);
        #1;
    endtask

    task automatic do_reset();
        dct_valid = 0; dct_code = 0; flush = 0; frame_ready = 0; overflow_clr = 0;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({dct_buffer, dct_count, frame_valid, frame_data, frame_count, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got buf=%h cnt=%0d fv=%b fd=%h fc=%0d ovf=%b, want all 0",
                     dct_buffer, dct_count, frame_valid, frame_data, frame_count, overflow);
        end
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < 15; i++) tick(1, 2'b01, 0, 1, 0);
        n_tests++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h15555555 || frame_count !== 4'd15) begin
            n_fail++;
            $display("FAIL full_frame: got fv=%b fd=%h fc=%0d, want 1 15555555 15",
                     frame_valid, frame_data, frame_count);
        end
        n_tests++;
        if (dct_count !== 4'd0 || dct_buffer !== 30'h0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_frame_clear: got cnt=%0d buf=%h ovf=%b, want 0 0 0",
                     dct_count, dct_buffer, overflow);
        end
    endtask

    task automatic test_flush();
        tick(1, 2'd3, 0, 1, 0);
        tick(1, 2'd2, 0, 1, 0);
        tick(1, 2'd1, 0, 1, 0);
        tick(0, 2'd0, 1, 1, 0);
        n_tests++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h1B || frame_count !== 4'd3 ||
            dct_count !== 4'd0 || dct_buffer !== 30'h0) begin
            n_fail++;
            $display("FAIL flush_partial: got fv=%b fd=%h fc=%0d cnt=%0d, want 1 1b 3 0",
                     frame_valid, frame_data, frame_count, dct_count);
        end
        tick(0, 2'd0, 1, 1, 0);
        n_tests++;
        if (frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty: got fv=%b, want 0", frame_valid);
        end
    endtask

    task automatic test_flush_with_code();
        tick(1, 2'd0, 0, 1, 0);
        tick(1, 2'd1, 0, 1, 0);
        tick(1, 2'd3, 1, 1, 0);
        n_tests++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h34 || frame_count !== 4'd3) begin
            n_fail++;
            $display("FAIL flush_same_cycle: got fv=%b fd=%h fc=%0d, want 1 34 3",
                     frame_valid, frame_data, frame_count);
        end
        tick(0, 2'd0, 0, 1, 0);
    endtask

    task automatic test_backpressure_overflow();
        for (int i = 0; i < 30; i++) tick(1, 2'b10, 0, 0, 0);
        n_tests++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h2AAAAAAA || frame_count !== 4'd15 ||
            dct_count !== 4'd15 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL held_full: got fv=%b fd=%h fc=%0d cnt=%0d ovf=%b, want 1 2aaaaaaa 15 15 0",
                     frame_valid, frame_data, frame_count, dct_count, overflow);
        end
        tick(1, 2'b10, 0, 0, 0);
        n_tests++;
        if (overflow !== 1'b1 || dct_count !== 4'd15) begin
            n_fail++;
            $display("FAIL drop_overflow: got ovf=%b cnt=%0d, want 1 15", overflow, dct_count);
        end
        tick(0, 2'd0, 0, 1, 0);
        n_tests++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h2AAAAAAA || frame_count !== 4'd15 ||
            dct_count !== 4'd0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_load: got fv=%b fd=%h fc=%0d cnt=%0d ovf=%b, want 1 2aaaaaaa 15 0 1",
                     frame_valid, frame_data, frame_count, dct_count, overflow);
        end
        tick(0, 2'd0, 0, 0, 1);
        n_tests++;
        if (overflow !== 1'b0 || frame_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_clr: got ovf=%b fv=%b, want 0 1", overflow, frame_valid);
        end
        tick(0, 2'd0, 0, 1, 0);
    endtask

    task automatic test_pending_flush();
        logic [29:0] exp;
        tick(1, 2'd2, 1, 0, 0);  // one-entry frame occupies the holding register
        tick(1, 2'd1, 0, 0, 0);
        tick(1, 2'd2, 0, 0, 0);
        tick(1, 2'd3, 0, 0, 0);
        tick(1, 2'd1, 0, 0, 0);
        tick(0, 2'd0, 1, 0, 0);
        tick(0, 2'd0, 0, 0, 0);
        n_tests++;
        if (frame_valid !== 1'b1 || frame_count !== 4'd1 || frame_data !== 30'h2 ||
            dct_count !== 4'd4) begin
            n_fail++;
            $display("FAIL pending_hold: got fv=%b fd=%h fc=%0d cnt=%0d, want 1 2 1 4",
                     frame_valid, frame_data, frame_count, dct_count);
        end
        tick(0, 2'd0, 0, 1, 0);
        exp = 30'h1 | (30'h2 << 2) | (30'h3 << 4) | (30'h1 << 6);
        n_tests++;
        if (frame_valid !== 1'b1 || frame_count !== 4'd4 || frame_data !== exp ||
            dct_count !== 4'd0) begin
            n_fail++;
            $display("FAIL pending_release: got fv=%b fd=%h fc=%0d cnt=%0d, want 1 %h 4 0",
                     frame_valid, frame_data, frame_count, dct_count, exp);
        end
        tick(0, 2'd0, 0, 1, 0);
    endtask

    task automatic test_async_reset();
        logic [29:0] exp = '0;
        logic [1:0]  c;
        tick(1, 2'd1, 1, 0, 0);
        for (int i = 0; i < 7; i++) tick(1, 2'd3, 0, 0, 0);
        #2;
        reset = 1;
        #1;
        n_tests++;
        if ({dct_buffer, dct_count, frame_valid, frame_data, frame_count, overflow} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got buf=%h cnt=%0d fv=%b fd=%h fc=%0d ovf=%b, want all 0",
                     dct_buffer, dct_count, frame_valid, frame_data, frame_count, overflow);
        end
        @(negedge clk);
        reset = 0;
        model_reset();
        for (int i = 0; i < 15; i++) begin
            c = 2'($urandom_range(0, 3));
            exp[2*i +: 2] = c;
            tick(1, c, 0, 1, 0);
        end
        n_tests++;
        if (frame_valid !== 1'b1 || frame_data !== exp || frame_count !== 4'd15) begin
            n_fail++;
            $display("FAIL post_reset_frame: got fv=%b fd=%h fc=%0d, want 1 %h 15",
                     frame_valid, frame_data, frame_count, exp);
        end
    endtask

    task automatic test_back_to_back();
        int frames = 0;
        for (int i = 0; i < 45; i++) begin
            tick(1, 2'($urandom_range(0, 3)), 0, 1, 0);
            if (frame_valid && dct_count == 4'd0 && frame_count == 4'd15) frames++;
        end
        n_tests++;
        if (frames !== 3 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL throughput: got frames=%0d ovf=%b, want 3 0", frames, overflow);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 19) == 0);
            n_tests++;
            if (dct_buffer !== pack(m_codes) || dct_count !== 4'(m_codes.size()) ||
                frame_valid !== m_hold_valid || overflow !== m_ovf ||
                (m_hold_valid && (frame_data !== m_hold_data ||
                                  frame_count !== 4'(m_hold_count)))) begin
                n_fail++;
                if (errs++ < 10)
                    $display("FAIL random[%0d]: got buf=%h cnt=%0d fv=%b fd=%h fc=%0d ovf=%b, want buf=%h cnt=%0d fv=%b fd=%h fc=%0d ovf=%b",
                             i, dct_buffer, dct_count, frame_valid, frame_data, frame_count,
                             overflow, pack(m_codes), m_codes.size(), m_hold_valid,
                             m_hold_data, m_hold_count, m_ovf);
            end
        end
    endtask

    initial begin
        reset = 0;
        test_reset();
        test_full_frame();
        test_flush();
        test_flush_with_code();
        test_backpressure_overflow();
        test_pending_flush();
        test_async_reset();
        test_back_to_back();
        do_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/digiclk_cpu_oci_dct_packer.md
Name: digiclk_cpu_oci_dct_packer

Overview:
Producer side of the CPU OCI data-compressed-trace (DCT) path. Packs 2-bit DCT codes from the OCI trace logic into 30-bit frames of up to 15 entries. Exposes the live fill state as dct_buffer/dct_count, the signals the OCI test-bench monitor consumes. Hands completed or flushed frames to the trace store through a valid/ready holding register.

Parameters:
ENTRY_W, 2, bits per DCT code (fixed; other values unsupported)
ENTRIES, 15, codes per frame; buffer width = ENTRY_W*ENTRIES = 30

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
dct_valid  input  1  dct_code valid this cycle
dct_code  input  2  trace code to append
flush  input  1  single-cycle request to emit a partial frame
frame_ready  input  1  downstream accepts frame this cycle
overflow_clr  input  1  clears sticky overflow
dct_buffer  output  30  registered fill buffer (entries not yet framed)
dct_count  output  4  registered entry count of dct_buffer, 0..15
frame_valid  output  1  holding register occupied
frame_data  output  30  held frame
frame_count  output  4  entries in held frame, 1..15
overflow  output  1  sticky: a code was dropped

Behaviour:
- Reset (async, any time, mid-frame included): dct_buffer=0, dct_count=0, frame_valid=0, frame_data=0, frame_count=0, overflow=0, flush_pending=0. Partial data is discarded.
- Entry k occupies dct_buffer[2k+1:2k]. Entry 0 is the first code after a frame boundary. Unused upper bits read 0.
- Accept: dct_valid=1 and dct_count<15. The code is written at index dct_count. dct_count increments at the next edge.
- Drop: dct_valid=1 with dct_count==15 (full, frame could not be pushed). The code is discarded and overflow=1 at the next edge.
- overflow_clr clears overflow. If a drop and overflow_clr occur in the same cycle, set wins.
- Holding register states:
  - EMPTY (frame_valid=0) and FULL (frame_valid=1).
  - A slot is available in a cycle when state is EMPTY, or state is FULL and frame_ready=1 (a transfer occurs that cycle).
  - frame_valid, frame_data and frame_count are stable while frame_valid=1 and frame_ready=0.
- Push decision uses count_next, the count after this cycle's accept:
  - push_full = count_next==15.
  - push_flush = (flush or flush_pending) and count_next>0.
  - If (push_full or push_flush) and a slot is available: frame_data = buffer including this cycle's code, frame_count = count_next, frame_valid=1. The fill buffer clears to 0/0 at the same edge. Frame latency is one clock after the accepting edge.
  - If a push is needed but no slot is available: the buffer retains its contents (count may sit at 15) and flush_pending stays or becomes 1.
- flush while count_next==0: no frame is produced and flush_pending clears.
- flush_pending clears on any successful push.
- Simultaneous dct_valid and flush: the code is included in the flushed frame.
- Simultaneous transfer and push: the new frame replaces the old one in the same edge and frame_valid stays 1 (back-to-back frames, no bubble).
- Transfer with no push: frame_valid=0 at the next edge.
- Full throughput: one code per clock sustained with frame_ready=1, no drops.

Test Plan:
1. Reset; frame_ready=1; 15 consecutive codes 2'b01 -> one clock after the 15th, frame_valid=1, frame_data=0x15555555, frame_count=15; dct_count=0, dct_buffer=0; overflow=0.
2. Codes 3,2,1 then flush alone -> frame_data=0x0000001B, frame_count=3, fill buffer clears; a second flush with dct_count=0 -> no frame.
3. Code 3 with flush in the same cycle after two codes 0,1 -> frame_data=0x34, frame_count=3.
4. frame_ready=0; 31 codes 2'b10 -> first frame held (0x2AAAAAAA, 15), dct_count=15, 31st code dropped, overflow=1. Raise frame_ready for one cycle -> second frame 0x2AAAAAAA loaded with frame_valid held at 1. overflow_clr -> overflow=0.
5. frame_ready=0 with a frame held; 4 codes then flush -> flush_pending, no new frame. Raise frame_ready -> partial frame with count 4 appears on the next edge.
6. Assert reset asynchronously mid-clock after 7 codes with a frame held -> all outputs 0 immediately. After release, the next 15 codes produce a frame with no stale entries.
